// File: rtl/ml_accel_ctrl.sv
// Accelerator control FSM: streams a DIM x DIM operand matrix into a local buffer,
// runs the compute engine under a watchdog and holds DONE/ERROR until the host acks.
module ml_accel_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIM     = 2,
  parameter int unsigned TIMEOUT = 256,
  localparam int unsigned NUM_ELEM = DIM * DIM,
  localparam int unsigned AW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1,
  localparam int unsigned CW = $clog2(NUM_ELEM + 1),
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              done,
  input  logic              ack,
  output logic              idle,
  output logic              busy,
  output logic              compute_en,
  output logic              done_flag,
  output logic              error,
  output logic [CW-1:0]     count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ELEM - 1);
  localparam logic [TW-1:0] TIMER_LIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] mem_q [NUM_ELEM];
  logic [DATA_W-1:0] mem_d [NUM_ELEM];

  // State, counters and operand buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      timer_q <= '0;
      for (int i = 0; i < int'(NUM_ELEM); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      for (int i = 0; i < int'(NUM_ELEM); i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic; buffer written only on accepted LOAD beats
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    for (int i = 0; i < int'(NUM_ELEM); i++) mem_d[i] = mem_q[i];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < int'(NUM_ELEM); i++) begin
            if (count_q == CW'(i)) mem_d[i] = in_data;
          end
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            state_d = S_BUSY;
            timer_d = '0;
          end
        end
      end
      S_BUSY: begin
        timer_d = timer_q + TW'(1);
        // done has priority over a simultaneous watchdog expiry
        if (done) begin
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LIM)) begin
          state_d = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Random-access read port; out-of-range addresses return zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_ELEM); i++) begin
      if (rd_addr == AW'(i)) rd_data = mem_q[i];
    end
  end

  assign idle       = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_BUSY);
  assign compute_en = busy;
  assign done_flag  = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign count      = count_q;

endmodule
